// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

endpackage

// File: rtl/ps2_rx_if.sv
// Scan-byte output bundle from the receiver towards the keyboard bus controller.
interface ps2_rx_if;

  logic [7:0] keycode_o;
  logic       keycode_valid_o;
  logic       err_o;

  modport master (
    output keycode_o,
    output keycode_valid_o,
    output err_o
  );

  modport slave (
    input keycode_o,
    input keycode_valid_o,
    input err_o
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises raw kclk/kdata pads and deglitches kclk; emits a strobe on each
// filtered falling edge alongside the synchronised data line.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic kclk_i,
  input  logic kdata_i,
  output logic fall_o,
  output logic kdata_o
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic [1:0]      kclk_sync_q, kclk_sync_d;
  logic [1:0]      kdata_sync_q, kdata_sync_d;
  logic            kclk_filt_q, kclk_filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            differ;
  logic            flip;

  assign differ = kclk_sync_q[1] != kclk_filt_q;
  assign flip   = differ && (cnt_q == CntW'(FILTER_LEN - 1));

  always_comb begin
    kclk_sync_d  = {kclk_sync_q[0], kclk_i};
    kdata_sync_d = {kdata_sync_q[0], kdata_i};
    kclk_filt_d  = kclk_filt_q;
    cnt_d        = '0;
    if (flip) begin
      kclk_filt_d = ~kclk_filt_q;
    end else if (differ) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      kclk_sync_q  <= 2'b11;
      kdata_sync_q <= 2'b11;
      kclk_filt_q  <= 1'b1;
      cnt_q        <= '0;
    end else begin
      kclk_sync_q  <= kclk_sync_d;
      kdata_sync_q <= kdata_sync_d;
      kclk_filt_q  <= kclk_filt_d;
      cnt_q        <= cnt_d;
    end
  end

  // Strobe is taken in the cycle the filtered level is about to drop.
  assign fall_o  = flip && kclk_filt_q;
  assign kdata_o = kdata_sync_q[1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: deserialises start/8 data/odd parity/stop frames into
// scan bytes, with an inactivity timeout that abandons stalled frames.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     kclk,
  input  logic     kdata,
  ps2_rx_if.master out_if
);

  localparam int unsigned BitCntW = $clog2(PS2_DATA_BITS);
  localparam int unsigned ToW     = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e               state_q, state_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                     parity_q, parity_d;
  logic [ToW-1:0]           to_cnt_q, to_cnt_d;
  logic [7:0]               keycode_q, keycode_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;

  logic fall;
  logic bit_in;
  logic timeout_hit;
  logic last_data_bit;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .kclk_i  (kclk),
    .kdata_i (kdata),
    .fall_o  (fall),
    .kdata_o (bit_in)
  );

  // Fires on the cycle that would carry the counter up to TIMEOUT_CYCLES.
  assign timeout_hit   = (state_q != StIdle) && !fall &&
                         (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
  assign last_data_bit = bit_cnt_q == BitCntW'(PS2_DATA_BITS - 1);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = StIdle;
    end else if (fall) begin
      unique case (state_q)
        StIdle:   if (!bit_in) state_d = StData;
        StData:   if (last_data_bit) state_d = StParity;
        StParity: state_d = StStop;
        StStop:   state_d = StIdle;
      endcase
    end
  end

  // Datapath and output next-state
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    keycode_d = keycode_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (state_q == StIdle || fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != ToW'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end

    if (timeout_hit) begin
      err_d = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!bit_in) begin
            shift_d   = '0;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {bit_in, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
        StParity: parity_d = bit_in;
        StStop: begin
          if (bit_in && ((^shift_q) ^ parity_q)) begin
            keycode_d = shift_q;
            valid_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
      keycode_q <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
      keycode_q <= keycode_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign out_if.keycode_o       = keycode_q;
  assign out_if.keycode_valid_o = valid_q;
  assign out_if.err_o           = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frame-level model predicts one strobe per complete
// frame; a per-cycle compare process matches DUT strobes and keycode against it.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 2000;
  localparam int          HALF = 40;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } ev_t;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic kclk = 1'b1;
  logic kdata = 1'b1;

  ps2_rx_if bus ();

  ps2_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .kclk    (kclk),
    .kdata   (kdata),
    .out_if  (bus)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  int   err_cyc = 0;
  ev_t  exp_q[$];
  logic [7:0] model_kc = 8'h00;

  always @(posedge clk_i) cyc++;

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  // A frame is good when its stop bit is 1 and data plus parity hold an odd count of ones.
  task automatic expect_frame(input logic [10:0] f);
    ev_t e;
    int ones = 0;
    for (int i = 1; i <= 9; i++) ones += int'(f[i]);
    e.data   = f[8:1];
    e.is_err = !(f[10] == 1'b1 && (ones % 2) == 1);
    exp_q.push_back(e);
  endtask

  task automatic wc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_after);
    for (int i = 0; i < nbits; i++) begin
      kdata = f[i];
      wc(HALF / 2);
      kclk = 1'b0;
      last_fall_cyc = cyc;
      wc(HALF);
      kclk = 1'b1;
      wc(HALF / 2);
      if (i == glitch_after) begin
        wc(5);
        kclk = 1'b0;
        wc(3);
        kclk = 1'b1;
        wc(5);
      end
    end
    if (nbits == PS2_FRAME_BITS) begin
      kdata = 1'b1;
      wc(2 * HALF);
    end
  endtask

  task automatic send_frame(input logic [10:0] f, input int glitch_after);
    expect_frame(f);
    send_bits(f, PS2_FRAME_BITS, glitch_after);
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      wc(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d strobes still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, want);
    end
  endtask

  // Per-cycle comparison against the frame model.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      model_kc = 8'h00;
    end else begin
      checks++;
      if (bus.keycode_valid_o === 1'b1 && bus.err_o === 1'b1) begin
        errors++;
        $display("FAIL both_strobes: valid=1 err=1 expected at most one");
      end
      if (bus.keycode_valid_o === 1'b1 || bus.err_o === 1'b1) begin
        if (bus.err_o === 1'b1) err_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_strobe: valid=%0b err=%0b expected none",
                   bus.keycode_valid_o, bus.err_o);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.is_err != (bus.err_o === 1'b1)) begin
            errors++;
            $display("FAIL strobe_kind: got err=%0b expected err=%0b (byte %02h)",
                     bus.err_o, e.is_err, e.data);
          end
          if (!e.is_err) model_kc = e.data;
        end
      end
      checks++;
      if (bus.keycode_o !== model_kc) begin
        errors++;
        $display("FAIL keycode: got %02h expected %02h", bus.keycode_o, model_kc);
      end
    end
  end

  initial begin
    int dt;
    rst_n_i = 1'b0;
    wc(5);
    check8("reset_keycode", bus.keycode_o, 8'h00);
    check8("reset_valid", {7'd0, bus.keycode_valid_o}, 8'h00);
    check8("reset_err", {7'd0, bus.err_o}, 8'h00);
    rst_n_i = 1'b1;
    wc(20);

    // Model pins: odd-parity bits and the bit order of 0x1C.
    check8("par_1c", {7'd0, odd_par(8'h1C)}, 8'h00);
    check8("par_f0", {7'd0, odd_par(8'hF0)}, 8'h01);
    check8("par_5a", {7'd0, odd_par(8'h5A)}, 8'h01);
    checks++;
    if (mk(8'h1C, 1'b0, 1'b1) !== 11'b100_0011_1000) begin
      errors++;
      $display("FAIL frame_1c: got %03h expected 438", mk(8'h1C, 1'b0, 1'b1));
    end

    send_frame(mk(8'h1C, odd_par(8'h1C), 1'b1), -1);
    drain("good_1c", 200);
    check8("kc_1c", bus.keycode_o, 8'h1C);

    send_frame(mk(8'hF0, odd_par(8'hF0), 1'b1), -1);
    drain("good_f0", 200);
    check8("kc_f0", bus.keycode_o, 8'hF0);
    send_frame(mk(8'h1C, odd_par(8'h1C), 1'b1), -1);
    drain("good_1c_b2b", 200);
    check8("kc_1c_b2b", bus.keycode_o, 8'h1C);

    send_frame(mk(8'h1C, 1'b1, 1'b1), -1);
    drain("bad_parity", 200);
    check8("kc_hold_parity", bus.keycode_o, 8'h1C);
    send_frame(mk(8'h1C, odd_par(8'h1C), 1'b0), -1);
    drain("bad_stop", 200);
    check8("kc_hold_stop", bus.keycode_o, 8'h1C);

    send_frame(mk(8'hF0, odd_par(8'hF0), 1'b1), -1);
    drain("good_f0_2", 200);
    kclk = 1'b0;
    wc(3);
    kclk = 1'b1;
    wc(50);
    send_frame(mk(8'h1C, odd_par(8'h1C), 1'b1), 3);
    drain("glitch_1c", 200);
    check8("kc_glitch", bus.keycode_o, 8'h1C);

    send_bits(mk(8'h5A, odd_par(8'h5A), 1'b1), 5, -1);
    kdata = 1'b1;
    exp_q.push_back('{is_err: 1'b1, data: 8'h00});
    drain("timeout", TO + 200);
    dt = err_cyc - last_fall_cyc;
    checks++;
    if (dt < int'(TO) || dt > int'(TO + FL + 10)) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d", dt, TO, TO + FL + 10);
    end
    wc(50);
    send_frame(mk(8'h5A, odd_par(8'h5A), 1'b1), -1);
    drain("good_5a", 200);
    check8("kc_5a", bus.keycode_o, 8'h5A);

    send_bits(mk(8'h1C, odd_par(8'h1C), 1'b1), 5, -1);
    rst_n_i = 1'b0;
    wc(2);
    check8("midrst_keycode", bus.keycode_o, 8'h00);
    check8("midrst_valid", {7'd0, bus.keycode_valid_o}, 8'h00);
    check8("midrst_err", {7'd0, bus.err_o}, 8'h00);
    kdata = 1'b1;
    wc(3);
    rst_n_i = 1'b1;
    wc(20);
    send_frame(mk(8'h1C, odd_par(8'h1C), 1'b1), -1);
    drain("post_rst_1c", 200);
    check8("kc_post_rst", bus.keycode_o, 8'h1C);

    wc(100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
